// File: rtl/icache_line_prefetcher_pkg.sv
// Shared types and constants for the icache next-line prefetcher.
package toy_pack;

    localparam int unsigned ADDR_WIDTH          = 32;
    localparam int unsigned TXNID_WIDTH         = 8;
    localparam int unsigned OPCODE_WIDTH        = 4;
    localparam int unsigned PF_SEQ_WIDTH        = 4;
    localparam int unsigned LINE_BYTES          = 64;
    localparam int unsigned ICACHE_OFFSET_WIDTH = 6;

    localparam logic [TXNID_WIDTH-1:0]  PF_TXNID_BASE   = 8'hA0;
    localparam logic [OPCODE_WIDTH-1:0] PREFETCH_OPCODE = 4'h6;

    typedef logic [ADDR_WIDTH-1:0] req_addr_t;

    typedef struct packed {
        req_addr_t                addr;
        logic [TXNID_WIDTH-1:0]   txnid;
        logic [OPCODE_WIDTH-1:0]  opcode;
    } pc_req_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } pf_state_e;

    // Clear the byte-offset bits to get the containing cache line.
    function automatic req_addr_t line_align(input req_addr_t addr);
        return addr & ~req_addr_t'(LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/icache_line_prefetcher_miss_queue.sv
// Miss-line FIFO with a parallel compare of an incoming line against all valid entries.
module icache_pf_miss_queue
    import toy_pack::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  logic      pop,
    input  req_addr_t push_line,
    input  req_addr_t cmp_line,
    output logic      full,
    output logic      empty,
    output logic      empty_nxt_c,
    output logic      dup_hit_c,
    output req_addr_t head_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    req_addr_t        entries_q [DEPTH];
    req_addr_t        entries_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             pop_ok_c, push_ok_c;

    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign pop_ok_c  = pop && !empty_q;
    assign push_ok_c = push && (!full_q || pop_ok_c);

    // Next-state of storage, pointers and occupancy; flush wins over everything.
    always_comb begin
        entries_d = entries_q;
        valid_d   = valid_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            valid_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_ok_c) begin
                valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d          = rd_ptr_q + PTR_W'(1);
            end
            if (push_ok_c) begin
                entries_d[wr_ptr_q] = push_line;
                valid_d[wr_ptr_q]   = 1'b1;
                wr_ptr_d            = wr_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Parallel duplicate search over every valid entry.
    always_comb begin
        dup_hit_c = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entries_q[i] == cmp_line)) begin
                dup_hit_c = 1'b1;
            end
        end
    end

    // Queue state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            entries_q <= entries_d;
            valid_q   <= valid_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
        end
    end

    assign full        = full_q;
    assign empty       = empty_q;
    assign empty_nxt_c = empty_d;
    assign head_c      = entries_q[rd_ptr_q];

endmodule

// File: rtl/icache_line_prefetcher.sv
// Next-line instruction prefetcher: queues demand-miss lines and issues up to
// PF_DEGREE same-page next-line requests per miss toward the icache arbiter.
// Optional statistics counters: define ICACHE_PREFETCH_STATS_EN.
module icache_line_prefetcher
    import toy_pack::*;
#(
    parameter int unsigned PF_DEGREE      = 2,
    parameter int unsigned PF_QUEUE_DEPTH = 4,
    parameter int unsigned PF_PAGE_BITS   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prefetch_enable,
    input  logic        miss_vld,
    input  req_addr_t   miss_addr,
    input  logic        pref_to_mshr_req_rdy,
    output logic        prefetch_req_vld,
    input  logic        prefetch_req_rdy,
    output pc_req_t     prefetch_req_pld,
    output logic        pf_busy,
    output logic [15:0] pf_issued_cnt,
    output logic [15:0] pf_dropped_cnt
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned STAT_W = 16;

    pf_state_e               state_q, state_d;
    req_addr_t               base_q, base_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PF_SEQ_WIDTH-1:0] seq_q, seq_d;
    logic                    vld_q, vld_d;
    pc_req_t                 pld_q, pld_d;
    logic                    busy_q, busy_d;

    req_addr_t cand_addr_c;
    req_addr_t miss_line_c;
    req_addr_t q_head_c;
    logic      hs_c, pop_c, push_c, miss_take_c, base_hit_c;
    logic      q_full, q_empty, q_empty_nxt_c, q_dup_hit_c;

    assign hs_c = vld_q && prefetch_req_rdy;

    // Miss capture: drop duplicates of queued lines or of the line being prefetched.
    assign miss_line_c = line_align(miss_addr);
    assign base_hit_c  = (state_q == ISSUE) && (miss_line_c == base_q);
    assign miss_take_c = miss_vld && prefetch_enable && !q_dup_hit_c && !base_hit_c;
    assign push_c      = miss_take_c && (!q_full || pop_c);

    icache_pf_miss_queue #(
        .DEPTH (PF_QUEUE_DEPTH)
    ) u_miss_queue (
        .clk         (clk),
        .rst         (rst),
        .flush       (!prefetch_enable),
        .push        (push_c),
        .pop         (pop_c),
        .push_line   (miss_line_c),
        .cmp_line    (miss_line_c),
        .full        (q_full),
        .empty       (q_empty),
        .empty_nxt_c (q_empty_nxt_c),
        .dup_hit_c   (q_dup_hit_c),
        .head_c      (q_head_c)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and burst bookkeeping; the page check looks at the line to be requested next.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        seq_d       = seq_q;
        pop_c       = 1'b0;
        cand_addr_c = '0;
        case (state_q)
            IDLE: begin
                if (prefetch_enable && !q_empty) begin
                    pop_c   = 1'b1;
                    base_d  = q_head_c;
                    cnt_d   = CNT_W'(1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (hs_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    seq_d = seq_q + PF_SEQ_WIDTH'(1);
                    if ((cnt_q == CNT_W'(PF_DEGREE)) || !prefetch_enable) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (!vld_q && !prefetch_enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cand_addr_c = base_d + (req_addr_t'(cnt_d) << ICACHE_OFFSET_WIDTH);
        if ((state_d == ISSUE) &&
            (cand_addr_c[ADDR_WIDTH-1:PF_PAGE_BITS] != base_d[ADDR_WIDTH-1:PF_PAGE_BITS])) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Output next-values; an asserted valid doubles as the hold flag until the handshake.
    always_comb begin
        vld_d  = vld_q;
        pld_d  = pld_q;
        busy_d = !q_empty_nxt_c || (state_d != IDLE);
        if (!vld_q || hs_c) begin
            vld_d = (state_d == ISSUE) && prefetch_enable && pref_to_mshr_req_rdy;
            pld_d = '0;
            if (vld_d) begin
                pld_d.addr   = cand_addr_c;
                pld_d.txnid  = PF_TXNID_BASE + TXNID_WIDTH'(seq_d);
                pld_d.opcode = PREFETCH_OPCODE;
            end
        end
    end

    // Burst datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            cnt_q  <= '0;
            seq_q  <= '0;
            vld_q  <= 1'b0;
            pld_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            base_q <= base_d;
            cnt_q  <= cnt_d;
            seq_q  <= seq_d;
            vld_q  <= vld_d;
            pld_q  <= pld_d;
            busy_q <= busy_d;
        end
    end

    assign prefetch_req_vld = vld_q;
    assign prefetch_req_pld = pld_q;
    assign pf_busy          = busy_q;

`ifdef ICACHE_PREFETCH_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    logic [STAT_W-1:0] issued_q, issued_d;
    logic [STAT_W-1:0] dropped_q, dropped_d;
    logic              full_drop_c;

    // Only capacity drops are counted; duplicate drops are expected traffic.
    assign full_drop_c = miss_take_c && q_full && !pop_c;

    // Saturating statistics counters.
    always_comb begin
        issued_d  = issued_q;
        dropped_d = dropped_q;
        if (hs_c && (issued_q != STAT_MAX)) begin
            issued_d = issued_q + STAT_W'(1);
        end
        if (full_drop_c && (dropped_q != STAT_MAX)) begin
            dropped_d = dropped_q + STAT_W'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q  <= '0;
            dropped_q <= '0;
        end else begin
            issued_q  <= issued_d;
            dropped_q <= dropped_d;
        end
    end

    assign pf_issued_cnt  = issued_q;
    assign pf_dropped_cnt = dropped_q;
`else
    assign pf_issued_cnt  = '0;
    assign pf_dropped_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_line_prefetcher.sv
// Directed plus randomized bench for icache_line_prefetcher against a transaction-level model.
module tb_icache_line_prefetcher;
    import toy_pack::*;

    localparam int unsigned DEG       = 2;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned PAGE_BITS = 12;
    localparam int unsigned SEQ_MOD   = 1 << PF_SEQ_WIDTH;
`ifdef ICACHE_PREFETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        req_addr_t              addr;
        logic [TXNID_WIDTH-1:0] txnid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prefetch_enable = 1'b0;
    logic        miss_vld = 1'b0;
    req_addr_t   miss_addr = '0;
    logic        pref_to_mshr_req_rdy = 1'b0;
    logic        prefetch_req_vld;
    logic        prefetch_req_rdy = 1'b0;
    pc_req_t     prefetch_req_pld;
    logic        pf_busy;
    logic [15:0] pf_issued_cnt;
    logic [15:0] pf_dropped_cnt;

    int      checks = 0;
    int      errors = 0;
    int      model_seq = 0;
    int      n_hs = 0;
    int      n_drop = 0;
    bit      hold_pend = 1'b0;
    pc_req_t held_pld = '0;
    exp_t    exp_q[$];

    always #5 clk = ~clk;

    icache_line_prefetcher #(
        .PF_DEGREE      (DEG),
        .PF_QUEUE_DEPTH (DEPTH),
        .PF_PAGE_BITS   (PAGE_BITS)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .prefetch_enable      (prefetch_enable),
        .miss_vld             (miss_vld),
        .miss_addr            (miss_addr),
        .pref_to_mshr_req_rdy (pref_to_mshr_req_rdy),
        .prefetch_req_vld     (prefetch_req_vld),
        .prefetch_req_rdy     (prefetch_req_rdy),
        .prefetch_req_pld     (prefetch_req_pld),
        .pf_busy              (pf_busy),
        .pf_issued_cnt        (pf_issued_cnt),
        .pf_dropped_cnt       (pf_dropped_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected requests for an accepted miss: successive lines up to the page end.
    task automatic add_miss_exp(input req_addr_t a);
        req_addr_t line;
        req_addr_t nxt;
        line = a - (a % req_addr_t'(LINE_BYTES));
        for (int k = 1; k <= int'(DEG); k++) begin
            nxt = line + req_addr_t'(k * int'(LINE_BYTES));
            if ((nxt >> PAGE_BITS) != (line >> PAGE_BITS)) break;
            exp_q.push_back('{addr: nxt, txnid: PF_TXNID_BASE + TXNID_WIDTH'(model_seq)});
            model_seq = (model_seq + 1) % SEQ_MOD;
        end
    endtask

    // One clock: check hold stability and any handshake in this cycle, then advance.
    task automatic tick();
        exp_t e;
        if (hold_pend) begin
            check("hold_vld", 64'(prefetch_req_vld), 64'(1'b1));
            check("hold_pld", 64'(prefetch_req_pld), 64'(held_pld));
        end
        if (prefetch_req_vld === 1'b1 && prefetch_req_rdy === 1'b1 && rst === 1'b0) begin
            n_hs++;
            check("req_expected", 64'(exp_q.size() > 0), 64'(1'b1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("req_addr", 64'(prefetch_req_pld.addr), 64'(e.addr));
                check("req_txnid", 64'(prefetch_req_pld.txnid), 64'(e.txnid));
                check("req_opcode", 64'(prefetch_req_pld.opcode), 64'(PREFETCH_OPCODE));
            end
        end
        hold_pend = (prefetch_req_vld === 1'b1) && (prefetch_req_rdy !== 1'b1) && (rst !== 1'b1);
        held_pld  = prefetch_req_pld;
        @(posedge clk);
        #1;
    endtask

    task automatic send_miss(input req_addr_t a, input bit accepted);
        miss_addr = a;
        miss_vld  = 1'b1;
        if (accepted) add_miss_exp(a);
        tick();
        miss_vld  = 1'b0;
    endtask

    // Run until everything expected has been issued and the block is idle.
    task automatic drain(input int budget, input bit rnd);
        int n = 0;
        while ((pf_busy !== 1'b0 || prefetch_req_vld !== 1'b0 || exp_q.size() != 0) && n < budget) begin
            if (rnd) begin
                prefetch_req_rdy     = ($urandom_range(0, 3) != 0);
                pref_to_mshr_req_rdy = ($urandom_range(0, 3) != 0);
            end else begin
                prefetch_req_rdy     = 1'b1;
                pref_to_mshr_req_rdy = 1'b1;
            end
            tick();
            n++;
        end
        check("drain_idle", {61'd0, pf_busy, prefetch_req_vld, exp_q.size() != 0}, 64'd0);
    endtask

    initial begin
        int hs0;
        req_addr_t lines[3];
        int nm;

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_vld", 64'(prefetch_req_vld), 64'd0);
        check("rst_busy", 64'(pf_busy), 64'd0);
        check("rst_pld", 64'(prefetch_req_pld), 64'd0);
        check("rst_issued", 64'(pf_issued_cnt), 64'd0);
        check("rst_dropped", 64'(pf_dropped_cnt), 64'd0);

        // Basic burst: two next lines, first valid two cycles after the miss, back to back.
        prefetch_enable      = 1'b1;
        prefetch_req_rdy     = 1'b1;
        pref_to_mshr_req_rdy = 1'b1;
        send_miss(32'h1000_0040, 1'b1);
        tick();
        check("t1_first_vld", 64'(prefetch_req_vld), 64'd1);
        check("t1_addr0", 64'(prefetch_req_pld.addr), 64'h1000_0080);
        check("t1_txnid0", 64'(prefetch_req_pld.txnid), 64'(PF_TXNID_BASE));
        tick();
        check("t1_b2b_vld", 64'(prefetch_req_vld), 64'd1);
        check("t1_addr1", 64'(prefetch_req_pld.addr), 64'h1000_00C0);
        check("t1_txnid1", 64'(prefetch_req_pld.txnid), 64'(PF_TXNID_BASE + 8'd1));
        drain(50, 1'b0);

        // Page crossing: nothing issued, idle within two cycles.
        send_miss(32'h1000_0FC0, 1'b1);
        tick();
        check("t2_vld", 64'(prefetch_req_vld), 64'd0);
        check("t2_busy", 64'(pf_busy), 64'd0);

        // Full queue while the MSHR has no room: the fifth miss is dropped.
        pref_to_mshr_req_rdy = 1'b0;
        send_miss(32'h3000_0000, 1'b1);
        tick();
        send_miss(32'h3000_1000, 1'b1);
        send_miss(32'h3000_2040, 1'b1);
        send_miss(32'h3000_3080, 1'b1);
        send_miss(32'h3000_40C0, 1'b1);
        send_miss(32'h3000_5100, 1'b0);
        n_drop++;
        check("t3_dropped", 64'(pf_dropped_cnt), STATS ? 64'(n_drop) : 64'd0);
        check("t3_no_vld", 64'(prefetch_req_vld), 64'd0);
        check("t3_busy", 64'(pf_busy), 64'd1);
        hs0 = n_hs;
        drain(100, 1'b0);
        check("t3_drained", 64'(n_hs - hs0), 64'd10);
        check("t3_issued", 64'(pf_issued_cnt), STATS ? 64'(n_hs) : 64'd0);

        // Duplicate line in the cycle it is popped: one burst only, not counted as a drop.
        send_miss(32'h2000_0000, 1'b1);
        send_miss(32'h2000_0010, 1'b0);
        hs0 = n_hs;
        drain(50, 1'b0);
        check("t4_one_burst", 64'(n_hs - hs0), 64'd2);
        check("t4_dropped", 64'(pf_dropped_cnt), STATS ? 64'(n_drop) : 64'd0);

        // Stall with MSHR headroom withdrawn: request held stable until ready.
        prefetch_req_rdy = 1'b0;
        send_miss(32'h4000_0100, 1'b1);
        tick();
        check("t5_vld", 64'(prefetch_req_vld), 64'd1);
        check("t5_addr", 64'(prefetch_req_pld.addr), 64'h4000_0140);
        pref_to_mshr_req_rdy = 1'b0;
        tick();
        tick();
        tick();
        prefetch_req_rdy = 1'b1;
        hs0 = n_hs;
        tick();
        check("t5_hs_done", 64'(n_hs - hs0), 64'd1);
        drain(50, 1'b0);

        // Disable with a held request and a queued miss: only the held one completes.
        prefetch_req_rdy = 1'b0;
        send_miss(32'h5000_0000, 1'b1);
        send_miss(32'h5000_1000, 1'b1);
        check("t6_vld", 64'(prefetch_req_vld), 64'd1);
        prefetch_enable = 1'b0;
        tick();
        tick();
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        model_seq = (model_seq + SEQ_MOD - 3) % SEQ_MOD;
        hs0 = n_hs;
        drain(50, 1'b0);
        check("t6_only_held", 64'(n_hs - hs0), 64'd1);
        prefetch_enable = 1'b1;

        // Reset mid-burst with three queued misses.
        prefetch_req_rdy = 1'b0;
        send_miss(32'h6000_0000, 1'b1);
        send_miss(32'h6000_1000, 1'b1);
        send_miss(32'h6000_2000, 1'b1);
        send_miss(32'h6000_3000, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        model_seq = 0;
        n_hs      = 0;
        n_drop    = 0;
        check("t7_vld", 64'(prefetch_req_vld), 64'd0);
        check("t7_busy", 64'(pf_busy), 64'd0);
        check("t7_issued", 64'(pf_issued_cnt), 64'd0);
        check("t7_dropped", 64'(pf_dropped_cnt), 64'd0);
        prefetch_req_rdy = 1'b1;
        send_miss(32'h7000_0000, 1'b1);
        tick();
        check("t7_seq_restart", 64'(prefetch_req_pld.txnid), 64'(PF_TXNID_BASE));
        drain(50, 1'b0);

        // Randomized groups of 1-3 distinct misses with random back-pressure.
        for (int it = 0; it < 30; it++) begin
            nm = int'($urandom_range(1, 3));
            for (int m = 0; m < nm; m++) begin
                lines[m] = $urandom;
                if ($urandom_range(0, 3) == 0) lines[m][11:6] = 6'h3E + 6'($urandom_range(0, 1));
                for (int p = 0; p < m; p++) begin
                    if (line_align(lines[p]) == line_align(lines[m])) lines[m] = lines[m] ^ 32'h0001_0000;
                end
            end
            for (int m = 0; m < nm; m++) begin
                prefetch_req_rdy     = ($urandom_range(0, 3) != 0);
                pref_to_mshr_req_rdy = ($urandom_range(0, 3) != 0);
                send_miss(lines[m], 1'b1);
            end
            drain(200, 1'b1);
        end
        check("final_issued", 64'(pf_issued_cnt), STATS ? 64'(n_hs) : 64'd0);
        check("final_dropped", 64'(pf_dropped_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
